// File: rtl/parser_pkg.sv
// Shared type codes, field lengths, FSM states and decoded-message layout
// for the order-message byte-stream parser.
package parser_pkg;

  localparam logic [7:0] MSG_ADD  = 8'h41;
  localparam logic [7:0] MSG_EXEC = 8'h45;
  localparam logic [7:0] MSG_DEL  = 8'h44;

  localparam int OID_BYTES   = 8;
  localparam int PRICE_BYTES = 4;
  localparam int VOL_BYTES   = 4;

  typedef enum logic [1:0] {
    ST_TYPE,
    ST_ORDER_ID,
    ST_PRICE,
    ST_VOLUME
  } parser_state_e;

  typedef struct packed {
    logic [7:0]  msg_type;
    logic [63:0] order_id;
    logic [31:0] price;
    logic [31:0] volume;
  } order_msg_t;

  function automatic logic is_known_type(input logic [7:0] t);
    return (t == MSG_ADD) || (t == MSG_EXEC) || (t == MSG_DEL);
  endfunction

endpackage

// File: rtl/msg_parser.sv
// Big-endian order-message decoder: one byte per cycle in, one decoded
// message per frame out through a single-entry valid/ready register.
module msg_parser
  import parser_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_type,
  output logic [63:0] out_order_id,
  output logic [31:0] out_price,
  output logic [31:0] out_volume,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] msg_count,
  output logic [15:0] err_count
);

  parser_state_e state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [7:0]    type_q, type_d;
  logic [63:0]   oid_q, oid_d;
  logic [31:0]   price_q, price_d;
  logic [31:0]   vol_q, vol_d;

  order_msg_t    out_q;
  logic          out_valid_q;
  logic [15:0]   msg_cnt_q, err_cnt_q;

  logic          accept;
  logic          complete;
  logic          drop;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // A held message only blocks input if it is not being consumed this cycle,
  // so a started frame can always run to completion.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    type_d   = type_q;
    oid_d    = oid_q;
    price_d  = price_q;
    vol_d    = vol_q;
    complete = 1'b0;
    drop     = 1'b0;
    if (accept) begin
      case (state_q)
        ST_TYPE: begin
          if (is_known_type(in_data)) begin
            type_d  = in_data;
            oid_d   = '0;
            price_d = '0;
            vol_d   = '0;
            cnt_d   = '0;
            state_d = ST_ORDER_ID;
          end else begin
            drop = 1'b1;
          end
        end
        ST_ORDER_ID: begin
          oid_d = {oid_q[55:0], in_data};
          if (cnt_q == 3'(OID_BYTES - 1)) begin
            cnt_d = '0;
            if (type_q == MSG_ADD) begin
              state_d = ST_PRICE;
            end else if (type_q == MSG_EXEC) begin
              state_d = ST_VOLUME;
            end else begin
              complete = 1'b1;
              state_d  = ST_TYPE;
            end
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        ST_PRICE: begin
          price_d = {price_q[23:0], in_data};
          if (cnt_q == 3'(PRICE_BYTES - 1)) begin
            cnt_d   = '0;
            state_d = ST_VOLUME;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        ST_VOLUME: begin
          vol_d = {vol_q[23:0], in_data};
          if (cnt_q == 3'(VOL_BYTES - 1)) begin
            cnt_d    = '0;
            complete = 1'b1;
            state_d  = ST_TYPE;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        default: state_d = ST_TYPE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_TYPE;
      cnt_q   <= '0;
      type_q  <= '0;
      oid_q   <= '0;
      price_q <= '0;
      vol_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      type_q  <= type_d;
      oid_q   <= oid_d;
      price_q <= price_d;
      vol_q   <= vol_d;
    end
  end

  // Output register: completion wins over consume, so a new message loads
  // even when the previous one leaves in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      msg_cnt_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (complete) begin
        out_q       <= '{msg_type: type_q, order_id: oid_d,
                         price: price_d, volume: vol_d};
        out_valid_q <= 1'b1;
        msg_cnt_q   <= sat_inc(msg_cnt_q);
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (drop) begin
        err_cnt_q <= sat_inc(err_cnt_q);
      end
    end
  end

  assign out_type     = out_q.msg_type;
  assign out_order_id = out_q.order_id;
  assign out_price    = out_q.price;
  assign out_volume   = out_q.volume;
  assign out_valid    = out_valid_q;
  assign msg_count    = msg_cnt_q;
  assign err_count    = err_cnt_q;

endmodule

// File: tb/tb_msg_parser.sv
// Bench for msg_parser: fixed frame table, hand-written corner sequences and
// a random byte stream scored against a frame-level reference model.
module tb_msg_parser;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  out_type;
  logic [63:0] out_order_id;
  logic [31:0] out_price;
  logic [31:0] out_volume;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] msg_count;
  logic [15:0] err_count;

  msg_parser dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_type(out_type), .out_order_id(out_order_id),
    .out_price(out_price), .out_volume(out_volume),
    .out_valid(out_valid), .out_ready(out_ready),
    .msg_count(msg_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  t;
    logic [63:0] oid;
    logic [31:0] price;
    logic [31:0] vol;
  } msg_t;

  typedef struct {
    logic [135:0] bytes;
    int           n;
    msg_t         e;
  } vec_t;

  int          total = 0;
  int          bad = 0;
  msg_t        exp_q[$];
  logic [7:0]  mbuf[$];
  int          m_msg = 0;
  int          m_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int flen(input logic [7:0] t);
    case (t)
      8'h41:   return 17;
      8'h45:   return 13;
      8'h44:   return 9;
      default: return 0;
    endcase
  endfunction

  // Frame-level model: collect a whole frame, then compute fields arithmetically.
  task automatic model_byte(input logic [7:0] b);
    msg_t m;
    if (mbuf.size() == 0 && flen(b) == 0) begin
      if (m_err < 65535) m_err++;
    end else begin
      mbuf.push_back(b);
      if (mbuf.size() == flen(mbuf[0])) begin
        m.t = mbuf[0]; m.oid = 0; m.price = 0; m.vol = 0;
        for (int i = 1; i <= 8; i++) m.oid = m.oid * 256 + 64'(mbuf[i]);
        if (m.t == 8'h41) begin
          for (int i = 9; i <= 12; i++) m.price = m.price * 256 + 32'(mbuf[i]);
          for (int i = 13; i <= 16; i++) m.vol = m.vol * 256 + 32'(mbuf[i]);
        end else if (m.t == 8'h45) begin
          for (int i = 9; i <= 12; i++) m.vol = m.vol * 256 + 32'(mbuf[i]);
        end
        exp_q.push_back(m);
        if (m_msg < 65535) m_msg++;
        mbuf.delete();
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (rst_n) begin
      chk("msg_count", 64'(msg_count), 64'(m_msg));
      chk("err_count", 64'(err_count), 64'(m_err));
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic r, output logic acc);
    msg_t e;
    in_valid = v; in_data = d; out_ready = r;
    #1;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_extra: got type %h with nothing expected", out_type);
      end else begin
        e = exp_q.pop_front();
        chk("sb_type", 64'(out_type), 64'(e.t));
        chk("sb_oid", out_order_id, e.oid);
        chk("sb_price", 64'(out_price), 64'(e.price));
        chk("sb_vol", 64'(out_volume), 64'(e.vol));
      end
    end
    acc = v && in_ready;
    if (acc) model_byte(d);
  endtask

  task automatic send(input logic [7:0] b, input logic r);
    logic acc;
    acc = 1'b0;
    for (int k = 0; k < 64 && !acc; k++) begin
      tick();
      drive(1'b1, b, r, acc);
    end
    chk("send_accept", 64'(acc), 64'd1);
  endtask

  task automatic idle(input int n, input logic r);
    logic acc;
    repeat (n) begin
      tick();
      drive(1'b0, 8'h00, r, acc);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_type", 64'(out_type), 64'd0);
    chk("rst_oid", out_order_id, 64'd0);
    chk("rst_price", 64'(out_price), 64'd0);
    chk("rst_vol", 64'(out_volume), 64'd0);
    chk("rst_msg_count", 64'(msg_count), 64'd0);
    chk("rst_err_count", 64'(err_count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    mbuf.delete(); exp_q.delete(); m_msg = 0; m_err = 0;
  endtask

  task automatic send_vec(input vec_t v, input logic r);
    for (int i = 0; i < v.n; i++) send(v.bytes[135 - 8*i -: 8], r);
  endtask

  vec_t vecs[4];
  logic [7:0] stream[$];

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    logic [7:0] b, t;
    int guard;

    vecs[0] = '{{8'h41, 64'h0123456789ABCDEF, 32'd10000, 32'd100}, 17,
                '{8'h41, 64'h0123456789ABCDEF, 32'd10000, 32'd100}};
    vecs[1] = '{{8'h45, 64'h1122334455667788, 32'h00000032, 32'h0}, 13,
                '{8'h45, 64'h1122334455667788, 32'h0, 32'h32}};
    vecs[2] = '{{8'h44, 64'hDEADBEEFCAFEF00D, 64'h0}, 9,
                '{8'h44, 64'hDEADBEEFCAFEF00D, 32'h0, 32'h0}};
    vecs[3] = '{{8'h41, 64'hFFFFFFFFFFFFFFFF, 32'hFFFFFFFF, 32'h80000001}, 17,
                '{8'h41, 64'hFFFFFFFFFFFFFFFF, 32'hFFFFFFFF, 32'h80000001}};

    do_reset();

    // Table: contiguous frames, output appears exactly one cycle after last byte.
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < vecs[v].n - 1; i++) send(vecs[v].bytes[135 - 8*i -: 8], 1'b1);
      tick();
      chk("pre_last_valid", 64'(out_valid), 64'd0);
      drive(1'b1, vecs[v].bytes[135 - 8*(vecs[v].n - 1) -: 8], 1'b1, acc);
      chk("last_accept", 64'(acc), 64'd1);
      tick();
      chk("tbl_valid", 64'(out_valid), 64'd1);
      chk("tbl_type", 64'(out_type), 64'(vecs[v].e.t));
      chk("tbl_oid", out_order_id, vecs[v].e.oid);
      chk("tbl_price", 64'(out_price), 64'(vecs[v].e.price));
      chk("tbl_vol", 64'(out_volume), 64'(vecs[v].e.vol));
      drive(1'b0, 8'h00, 1'b1, acc);
    end
    tick();
    chk("tbl_msg_count", 64'(msg_count), 64'd4);
    drive(1'b0, 8'h00, 1'b1, acc);

    // Execute then Delete with no gap; in_ready must never drop.
    do_reset();
    for (int i = 0; i < 13; i++) stream.push_back(vecs[1].bytes[135 - 8*i -: 8]);
    for (int i = 0; i < 9; i++) stream.push_back(vecs[2].bytes[135 - 8*i -: 8]);
    while (stream.size() > 0) begin
      tick();
      drive(1'b1, stream.pop_front(), 1'b1, acc);
      chk("b2b_ready", 64'(acc), 64'd1);
    end
    idle(2, 1'b1);
    chk("b2b_msgs", 64'(msg_count), 64'd2);
    chk("b2b_drained", 64'(exp_q.size()), 64'd0);

    // Garbage resync.
    do_reset();
    send(8'h5A, 1'b1);
    send(8'hFF, 1'b1);
    send_vec(vecs[0], 1'b1);
    idle(2, 1'b1);
    chk("resync_err", 64'(err_count), 64'd2);
    chk("resync_msg", 64'(msg_count), 64'd1);
    chk("resync_drained", 64'(exp_q.size()), 64'd0);

    // Backpressure: held message blocks input until one consume cycle.
    do_reset();
    send_vec(vecs[2], 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      drive(1'b1, 8'h45, 1'b0, acc);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_hold_oid", out_order_id, 64'hDEADBEEFCAFEF00D);
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
    end
    tick();
    drive(1'b1, 8'h45, 1'b1, acc);
    chk("bp_release_accept", 64'(acc), 64'd1);
    for (int i = 1; i < 13; i++) send(vecs[1].bytes[135 - 8*i -: 8], 1'b0);
    tick();
    chk("bp_second_valid", 64'(out_valid), 64'd1);
    chk("bp_second_vol", 64'(out_volume), 64'h32);
    drive(1'b0, 8'h00, 1'b1, acc);
    idle(1, 1'b1);
    chk("bp_drained", 64'(exp_q.size()), 64'd0);

    // Reset mid-frame: partial Add discarded, next byte is a type byte.
    do_reset();
    for (int i = 0; i < 5; i++) send(vecs[0].bytes[135 - 8*i -: 8], 1'b1);
    do_reset();
    send_vec(vecs[2], 1'b1);
    idle(2, 1'b1);
    chk("midrst_msg", 64'(msg_count), 64'd1);
    chk("midrst_drained", 64'(exp_q.size()), 64'd0);

    // Random frames, garbage, input gaps and output stalls.
    do_reset();
    for (int f = 0; f < 60; f++) begin
      if ($urandom_range(0, 9) == 0) begin
        b = 8'($urandom_range(0, 255));
        if (flen(b) != 0) b = b ^ 8'h80;
        stream.push_back(b);
      end else begin
        case ($urandom_range(0, 2))
          0:       t = 8'h41;
          1:       t = 8'h45;
          default: t = 8'h44;
        endcase
        stream.push_back(t);
        for (int k = 1; k < flen(t); k++) stream.push_back(8'($urandom_range(0, 255)));
      end
    end
    guard = 0;
    while (stream.size() > 0 && guard < 20000) begin
      tick();
      drive(1'($urandom_range(0, 3) != 0), stream[0], 1'($urandom_range(0, 9) < 7), acc);
      if (acc) void'(stream.pop_front());
      guard++;
    end
    chk("rnd_stream_done", 64'(stream.size()), 64'd0);
    idle(3, 1'b1);
    chk("rnd_drained", 64'(exp_q.size()), 64'd0);
    stream.delete();

    // Error counter saturation.
    do_reset();
    for (int k = 0; k < 65537; k++) begin
      tick();
      drive(1'b1, 8'h00, 1'b1, acc);
    end
    tick();
    chk("err_saturated", 64'(err_count), 64'hFFFF);
    drive(1'b0, 8'h00, 1'b1, acc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
